if_queue_mp: RTL and testbench

IF_QUEUE_MP -- requirements
Module: if_queue_mp

---
 rtl/if_queue_mp.sv | 103 ++++++++++
 tb/tb_if_queue_mp.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/if_queue_mp.sv
// Multi-port instruction fetch queue: up to ENQ_W in-order writes and DEQ_W in-order
// reads per cycle, first-word fall-through output, flush and synchronous reset.
module if_queue_mp #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ENQ_W  = 2,
  parameter int DEQ_W  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [ENQ_W-1:0]          enq_valid,
  input  logic [ENQ_W*DATA_W-1:0]   enq_data,
  output logic                      enq_ready,
  output logic [DEQ_W-1:0]          deq_valid,
  output logic [DEQ_W*DATA_W-1:0]   deq_data,
  input  logic [DEQ_W-1:0]          deq_take,
  output logic [$clog2(DEPTH):0]    count,
  output logic [$clog2(DEPTH):0]    free
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     head;
  logic [AW-1:0]     tail;
  logic [CW-1:0]     enq_num;
  logic [CW-1:0]     enq_acc;
  logic [CW-1:0]     take_num;
  logic              take_run;
  logic              do_enq;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    enq_num = '0;
    for (int i = 0; i < ENQ_W; i++) begin
      enq_num = enq_num + CW'(enq_valid[i]);
    end
  end

  // Only the unbroken run of taken-and-valid lanes from lane 0 counts.
  always_comb begin
    take_num = '0;
    take_run = 1'b1;
    for (int i = 0; i < DEQ_W; i++) begin
      if (take_run && deq_take[i] && deq_valid[i]) begin
        take_num = take_num + 1'b1;
      end else begin
        take_run = 1'b0;
      end
    end
  end

  always_comb begin
    deq_valid = '0;
    deq_data  = '0;
    for (int i = 0; i < DEQ_W; i++) begin
      deq_valid[i]                  = (count > CW'(i));
      deq_data[i*DATA_W +: DATA_W]  = mem[head + AW'(i)];
    end
  end

  // Readiness looks only at registered occupancy; a same-cycle dequeue earns no credit.
  assign free      = CW'(DEPTH) - count;
  assign enq_ready = (free >= enq_num);
  assign do_enq    = enq_ready && !flush;
  assign enq_acc   = do_enq ? enq_num : '0;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(take_num);
      tail  <= tail + AW'(enq_acc);
      count <= count + enq_acc - take_num;
    end
  end

  // NOTE: storage is deliberately not reset; occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENQ_W; i++) begin
      if (do_enq && enq_valid[i]) begin
        mem[tail + AW'(i)] <= enq_data[i*DATA_W +: DATA_W];
      end
    end
  end

`ifndef SYNTHESIS
  // Valid lanes must be packed from lane 0 with no holes.
  enq_mask_contiguous: assert property (@(posedge clk) disable iff (!rst_n)
    ((enq_valid & (enq_valid + ENQ_W'(1))) == '0))
    else $error("enq_valid mask is not contiguous from lane 0");
`endif

endmodule

// File: tb/tb_if_queue_mp.sv
// Self-checking bench for if_queue_mp: hand-derived vector table, directed corner
// sequences and randomized traffic compared against a queue-based reference model.
module tb_if_queue_mp;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [1:0]  enq_valid;
  logic [63:0] enq_data;
  logic        enq_ready;
  logic [1:0]  deq_valid;
  logic [63:0] deq_data;
  logic [1:0]  deq_take;
  logic [4:0]  count;
  logic [4:0]  free;

  if_queue_mp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ENQ_W(2), .DEQ_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .enq_valid(enq_valid), .enq_data(enq_data), .enq_ready(enq_ready),
    .deq_valid(deq_valid), .deq_data(deq_data), .deq_take(deq_take),
    .count(count), .free(free)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the queue contents, oldest first.
  logic [31:0] q [$];

  // DUT outputs captured before the edge of the most recent cycle.
  int          obs_count, obs_free;
  logic [1:0]  obs_dv;
  logic        obs_ready;
  logic [31:0] obs_d [2];
  int          last_taken, last_acc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic f, input logic [1:0] ev,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] take);
    int   n, taken;
    logic exp_ready;
    @(negedge clk);
    rst_n = r; flush = f; enq_valid = ev; enq_data = {d1, d0}; deq_take = take;
    #1;
    n         = q.size();
    exp_ready = ((DEPTH - n) >= $countones(ev));
    obs_count = int'(count); obs_free = int'(free); obs_dv = deq_valid; obs_ready = enq_ready;
    obs_d[0]  = deq_data[31:0]; obs_d[1] = deq_data[63:32];
    check("model_count", count, n);
    check("model_free", free, DEPTH - n);
    check("model_deq_valid", deq_valid, {n > 1, n > 0});
    check("model_enq_ready", enq_ready, exp_ready);
    for (int i = 0; i < 2; i++) if (n > i) check("model_deq_data", obs_d[i], q[i]);
    @(posedge clk);
    last_taken = 0; last_acc = 0;
    if (!r || f) begin
      q.delete();
    end else begin
      taken = 0;
      for (int i = 0; i < 2; i++) if (take[i] && i < n && taken == i) taken++;
      for (int i = 0; i < taken; i++) void'(q.pop_front());
      if (exp_ready) begin
        if (ev[0]) begin q.push_back(d0); last_acc++; end
        if (ev[1]) begin q.push_back(d1); last_acc++; end
      end
      last_taken = taken;
    end
  endtask

  function automatic logic [1:0] rand_mask();
    case ($urandom_range(0, 2))
      0:       return 2'b00;
      1:       return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  typedef struct {
    logic [1:0]  ev;
    logic [31:0] d0, d1;
    logic [1:0]  take;
    int          exp_count;
    logic [1:0]  exp_dv;
    logic        exp_ready;
    logic [31:0] exp_d0, exp_d1;
  } vec_t;

  vec_t vec [9];
  int   send_seq, out_seq, budget;

  initial begin
    // Expected outputs observed before each edge, with that row's inputs applied.
    vec[0] = '{2'b11, 32'h11, 32'h22, 2'b00, 0, 2'b00, 1'b1, 32'h0,  32'h0};
    vec[1] = '{2'b00, 32'h0,  32'h0,  2'b00, 2, 2'b11, 1'b1, 32'h11, 32'h22};
    vec[2] = '{2'b01, 32'h33, 32'h0,  2'b01, 2, 2'b11, 1'b1, 32'h11, 32'h22};
    vec[3] = '{2'b00, 32'h0,  32'h0,  2'b10, 2, 2'b11, 1'b1, 32'h22, 32'h33};
    vec[4] = '{2'b00, 32'h0,  32'h0,  2'b11, 2, 2'b11, 1'b1, 32'h22, 32'h33};
    vec[5] = '{2'b00, 32'h0,  32'h0,  2'b11, 0, 2'b00, 1'b1, 32'h0,  32'h0};
    vec[6] = '{2'b11, 32'h44, 32'h55, 2'b00, 0, 2'b00, 1'b1, 32'h0,  32'h0};
    vec[7] = '{2'b00, 32'h0,  32'h0,  2'b01, 2, 2'b11, 1'b1, 32'h44, 32'h55};
    vec[8] = '{2'b00, 32'h0,  32'h0,  2'b00, 1, 2'b01, 1'b1, 32'h55, 32'h0};

    rst_n = 1'b0; flush = 1'b0; enq_valid = '0; enq_data = '0; deq_take = '0;
    cycle(0, 0, 2'b00, 0, 0, 2'b00);
    cycle(0, 0, 2'b11, 32'hDEAD, 32'hBEEF, 2'b11);
    check("reset_free", free, DEPTH);
    check("reset_ready", enq_ready, 1'b1);

    for (int i = 0; i < 9; i++) begin
      cycle(1, 0, vec[i].ev, vec[i].d0, vec[i].d1, vec[i].take);
      check($sformatf("vec%0d_count", i), obs_count, vec[i].exp_count);
      check($sformatf("vec%0d_dv", i), obs_dv, vec[i].exp_dv);
      check($sformatf("vec%0d_ready", i), obs_ready, vec[i].exp_ready);
      if (vec[i].exp_dv[0]) check($sformatf("vec%0d_d0", i), obs_d[0], vec[i].exp_d0);
      if (vec[i].exp_dv[1]) check($sformatf("vec%0d_d1", i), obs_d[1], vec[i].exp_d1);
    end

    // Fill to full, then take two.
    cycle(1, 1, 2'b00, 0, 0, 2'b00);
    for (int k = 0; k < 8; k++) cycle(1, 0, 2'b11, 32'h100 + 2*k, 32'h101 + 2*k, 2'b00);
    cycle(1, 0, 2'b01, 32'hF00D, 0, 2'b00);
    check("full_count", obs_count, 16);
    check("full_free", obs_free, 0);
    check("full_ready_01", obs_ready, 1'b0);
    cycle(1, 0, 2'b00, 0, 0, 2'b11);
    check("full_ready_00", obs_ready, 1'b1);
    check("full_head", obs_d[0], 32'h100);
    cycle(1, 0, 2'b00, 0, 0, 2'b00);
    check("after_take_count", obs_count, 14);

    // count=15 with two lanes offered and one taken: no write, count drops to 14.
    cycle(1, 0, 2'b01, 32'h1E, 0, 2'b00);
    cycle(1, 0, 2'b11, 32'hAAAA, 32'hBBBB, 2'b01);
    check("c15_count", obs_count, 15);
    check("c15_ready", obs_ready, 1'b0);
    cycle(1, 0, 2'b00, 0, 0, 2'b00);
    check("c15_after_count", obs_count, 14);

    // Flush at count=9 with a concurrent enqueue.
    cycle(1, 0, 2'b00, 0, 0, 2'b11);
    cycle(1, 0, 2'b00, 0, 0, 2'b11);
    cycle(1, 0, 2'b00, 0, 0, 2'b01);
    cycle(1, 1, 2'b11, 32'hBAD0, 32'hBAD1, 2'b11);
    check("flush_pre_count", obs_count, 9);
    cycle(1, 0, 2'b11, 32'hA1, 32'hA2, 2'b00);
    check("flush_count", obs_count, 0);
    check("flush_dv", obs_dv, 2'b00);
    check("flush_ready", obs_ready, 1'b1);
    cycle(1, 0, 2'b00, 0, 0, 2'b00);
    check("postflush_count", obs_count, 2);
    check("postflush_d0", obs_d[0], 32'hA1);
    check("postflush_d1", obs_d[1], 32'hA2);

    // Mid-stream reset at count=7, overriding a concurrent enqueue.
    cycle(1, 0, 2'b11, 32'hB1, 32'hB2, 2'b00);
    cycle(1, 0, 2'b11, 32'hB3, 32'hB4, 2'b00);
    cycle(1, 0, 2'b01, 32'hB5, 0, 2'b00);
    cycle(0, 0, 2'b11, 32'hDD, 32'hEE, 2'b01);
    check("rst_pre_count", obs_count, 7);
    cycle(1, 0, 2'b11, 32'hC1, 32'hC2, 2'b00);
    check("rst_count", obs_count, 0);
    check("rst_free", obs_free, 16);
    cycle(1, 0, 2'b00, 0, 0, 2'b11);
    check("refill_count", obs_count, 2);
    check("refill_d0", obs_d[0], 32'hC1);
    check("refill_d1", obs_d[1], 32'hC2);

    // Ordered stream 1..40 with random take masks.
    send_seq = 1; out_seq = 1; budget = 0;
    while (out_seq <= 40 && budget < 2000) begin
      logic [1:0] ev;
      ev = rand_mask();
      if (send_seq > 40) ev = 2'b00;
      else if (send_seq == 40 && ev == 2'b11) ev = 2'b01;
      cycle(1, 0, ev, send_seq, send_seq + 1, 2'($urandom_range(0, 3)));
      for (int i = 0; i < last_taken; i++) begin
        check("stream_order", obs_d[i], out_seq);
        out_seq++;
      end
      send_seq += last_acc;
      budget++;
    end
    check("stream_complete", out_seq, 41);
    cycle(1, 0, 2'b00, 0, 0, 2'b00);
    check("stream_empty", obs_count, 0);

    // General random traffic with occasional flush and reset.
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 19) == 0), rand_mask(),
            $urandom, $urandom, 2'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
